tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Parametrised square-wave melody engine for lobby, game-over and in-game sound cues.
- Walks an external note ROM of half-period values, one note per beat, and produces a signed sample for the Audio_Controller left/right output path.
- Adds the following behaviour to the single-tune player:
  - explicit start/stop control
  - one-shot or loop mode
  - rest notes
  - an end-of-melody marker
  - a done pulse
  - half-period latched per note, so a ROM change mid-note cannot corrupt the current tone

Parameters:
ADDR_W, 10, note ROM address width
DELAY_W, 19, half-period width in CLOCK_50 cycles
NOTE_COUNT, 1000, notes in melody; last address is NOTE_COUNT-1 (must be <= 2^ADDR_W)
BEAT_CYCLES, 2500000, PLAY cycles per note
BEAT_W, 23, beat counter width (must hold BEAT_CYCLES-1)
SAMPLE_W, 32, output sample width
AMPLITUDE, 100000000, positive sample magnitude (must be < 2^(SAMPLE_W-1))
ROM_LAT, 1, CLOCK_50 edges from rom_addr change to rom_q valid

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  begin melody from address 0; level, sampled each edge
stop  in  1  abort playback; level
loop_en  in  1  1 = restart at address 0 after last note; 0 = one-shot
rom_addr  out  ADDR_W  note ROM address
rom_q  in  DELAY_W  half-period of the addressed note
sample  out  SAMPLE_W  signed two's-complement square-wave sample
playing  out  1  high in FETCH and PLAY
done  out  1  one-cycle pulse on natural one-shot completion

Behaviour:
- Reset (asynchronous, resetn=0):
  - state IDLE
  - rom_addr=0, sample=0, playing=0, done=0
  - all counters and phase cleared
- All outputs are driven from registers only; there is no combinational path from any input.
- States: IDLE, FETCH, PLAY.
- IDLE:
  - sample=0, playing=0.
  - start=1 and stop=0 -> FETCH with rom_addr=0.
- FETCH:
  - Lasts exactly ROM_LAT+1 cycles; sample=0.
  - On the last edge:
    - rom_q is latched into half_period.
    - delay_cnt=0, beat_cnt=0, phase=0.
    - -> PLAY.
  - Exception: if rom_q is all ones (end marker), the melody-end rule is applied immediately and PLAY is not entered.
- PLAY:
  - half_period=0 is a rest: sample=0 and phase is frozen.
  - Otherwise:
    - sample = phase ? +AMPLITUDE : -AMPLITUDE.
    - delay_cnt increments each cycle.
    - At delay_cnt==half_period-1, phase toggles and delay_cnt is cleared, so each level lasts exactly half_period cycles.
    - half_period=1 toggles every cycle.
  - beat_cnt increments each cycle. At beat_cnt==BEAT_CYCLES-1 (PLAY lasts exactly BEAT_CYCLES cycles):
    - rom_addr < NOTE_COUNT-1: rom_addr+1 -> FETCH.
    - Otherwise the melody-end rule applies.
- Melody-end rule:
  - loop_en=1: rom_addr=0 -> FETCH; done stays 0.
  - loop_en=0: -> IDLE; rom_addr=0; done=1 for exactly one cycle (the first IDLE cycle).
  - loop_en is sampled only at this decision point.
- Per-note period: ROM_LAT+1+BEAT_CYCLES cycles.
- stop=1 in any state: -> IDLE on the next edge; sample=0, rom_addr=0, no done pulse.
- stop and start asserted together: stop wins.
- start while playing=1 is ignored, with no restart. A start still held when IDLE is re-entered after done re-triggers playback on the next edge.
- An asynchronous reset mid-note returns to the reset state immediately. Playback resumes only after a new start.
- Width rules:
  - Counters compare with equality only and never wrap past their terminal value.
  - sample negation is computed at SAMPLE_W width.

Test Plan:
1. NOTE_COUNT=3, BEAT_CYCLES=16, ROM_LAT=1, AMPLITUDE=100, ROM=[4,0,2], loop_en=0; pulse start.
   - Required:
     - 2 FETCH cycles of sample=0.
     - Note 0: 16 cycles of -100×4, +100×4, -100×4, +100×4.
     - Note 1: 2 FETCH cycles, then 16 cycles of 0.
     - Note 2: 2 FETCH cycles, then alternating -100,-100,+100,+100 for 16 cycles.
     - Then done=1 for one cycle, playing=0, rom_addr=0.
2. Same setup with loop_en=1.
   - Required: after note 2, rom_addr returns to 0 and the note 0 waveform repeats; done never asserts; playing stays 1 over 3 iterations.
3. ROM=[4, all-ones, 2], loop_en=0.
   - Required: note 0 plays 16 cycles; FETCH of address 1 ends with done=1; address 2 is never played.
4. stop=1 asserted 7 cycles into note 0's PLAY.
   - Required: next cycle IDLE, sample=0, rom_addr=0, playing=0, done=0.
5. start held during playback, plus start=stop=1 in IDLE.
   - Required: no restart during playback (rom_addr sequence unchanged); the IDLE case stays IDLE.
6. resetn pulled low mid-PLAY at an arbitrary non-edge time.
   - Required: outputs go to reset values immediately; after release, the block remains IDLE until start.

Source files
------------

// File: rtl/tone_sequencer.sv
// tone_sequencer: square-wave melody engine that walks an external note ROM of
// half-period values, one note per beat. It supports start/stop control,
// one-shot or loop mode, rest notes, an end-of-melody marker and a done pulse.
// Every output is registered, so no input has a combinational path to an output.
module tone_sequencer #(
   parameter int ADDR_W      = 10,
   parameter int DELAY_W     = 19,
   parameter int NOTE_COUNT  = 1000,
   parameter int BEAT_CYCLES = 2500000,
   parameter int BEAT_W      = 23,
   parameter int SAMPLE_W    = 32,
   parameter int AMPLITUDE   = 100000000,
   parameter int ROM_LAT     = 1
) (
   input  logic                       CLOCK_50,
   input  logic                       resetn,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       loop_en,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [DELAY_W-1:0]         rom_q,
   output logic signed [SAMPLE_W-1:0] sample,
   output logic                       playing,
   output logic                       done
);

   localparam int FETCH_W = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);

   localparam logic [FETCH_W-1:0]         FETCH_LAST = FETCH_W'(ROM_LAT);
   localparam logic [BEAT_W-1:0]          BEAT_LAST  = BEAT_W'(BEAT_CYCLES - 1);
   localparam logic [ADDR_W-1:0]          ADDR_LAST  = ADDR_W'(NOTE_COUNT - 1);
   localparam logic signed [SAMPLE_W-1:0] AMP_POS    = SAMPLE_W'(AMPLITUDE);
   localparam logic signed [SAMPLE_W-1:0] AMP_NEG    = -AMP_POS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_PLAY
   } state_t;

   state_t                state, state_nx;
   logic [ADDR_W-1:0]     rom_addr_nx;
   logic [DELAY_W-1:0]    half_period, half_period_nx;
   logic [DELAY_W-1:0]    delay_cnt, delay_cnt_nx;
   logic [BEAT_W-1:0]     beat_cnt, beat_cnt_nx;
   logic [FETCH_W-1:0]    fetch_cnt, fetch_cnt_nx;
   logic                  phase, phase_nx;
   logic signed [SAMPLE_W-1:0] sample_nx;
   logic                  playing_nx;
   logic                  done_nx;
   logic                  melody_end;

   // State, counters and registered outputs.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         rom_addr    <= '0;
         half_period <= '0;
         delay_cnt   <= '0;
         beat_cnt    <= '0;
         fetch_cnt   <= '0;
         phase       <= 1'b0;
         sample      <= '0;
         playing     <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nx;
         rom_addr    <= rom_addr_nx;
         half_period <= half_period_nx;
         delay_cnt   <= delay_cnt_nx;
         beat_cnt    <= beat_cnt_nx;
         fetch_cnt   <= fetch_cnt_nx;
         phase       <= phase_nx;
         sample      <= sample_nx;
         playing     <= playing_nx;
         done        <= done_nx;
      end
   end

   // Next-state logic; outputs are derived from the next-state values so that
   // the registered outputs line up with the state they describe.
   always_comb begin
      state_nx       = state;
      rom_addr_nx    = rom_addr;
      half_period_nx = half_period;
      delay_cnt_nx   = delay_cnt;
      beat_cnt_nx    = beat_cnt;
      fetch_cnt_nx   = fetch_cnt;
      phase_nx       = phase;
      done_nx        = 1'b0;
      melody_end     = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx     = S_FETCH;
               rom_addr_nx  = '0;
               fetch_cnt_nx = '0;
            end
         end
         S_FETCH: begin
            if (fetch_cnt == FETCH_LAST) begin
               if (&rom_q) begin
                  melody_end = 1'b1;
               end else begin
                  half_period_nx = rom_q;
                  delay_cnt_nx   = '0;
                  beat_cnt_nx    = '0;
                  phase_nx       = 1'b0;
                  state_nx       = S_PLAY;
               end
            end else begin
               fetch_cnt_nx = fetch_cnt + FETCH_W'(1);
            end
         end
         S_PLAY: begin
            // A zero half-period is a rest: phase and delay counter hold.
            if (half_period != '0) begin
               if (delay_cnt == half_period - DELAY_W'(1)) begin
                  phase_nx     = ~phase;
                  delay_cnt_nx = '0;
               end else begin
                  delay_cnt_nx = delay_cnt + DELAY_W'(1);
               end
            end
            if (beat_cnt == BEAT_LAST) begin
               if (rom_addr != ADDR_LAST) begin
                  rom_addr_nx  = rom_addr + ADDR_W'(1);
                  fetch_cnt_nx = '0;
                  state_nx     = S_FETCH;
               end else begin
                  melody_end = 1'b1;
               end
            end else begin
               beat_cnt_nx = beat_cnt + BEAT_W'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // End marker and last-note completion share one decision point.
      if (melody_end) begin
         rom_addr_nx = '0;
         if (loop_en) begin
            state_nx     = S_FETCH;
            fetch_cnt_nx = '0;
         end else begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
         end
      end

      // stop overrides everything, including a simultaneous start.
      if (stop) begin
         state_nx    = S_IDLE;
         rom_addr_nx = '0;
         done_nx     = 1'b0;
      end

      playing_nx = (state_nx != S_IDLE);
      if (state_nx == S_PLAY && half_period_nx != '0)
         sample_nx = phase_nx ? AMP_POS : AMP_NEG;
      else
         sample_nx = '0;
   end

endmodule

// File: tb/tb_tone_sequencer.sv
// Testbench for tone_sequencer: small melody parameters, a registered ROM model
// and an expected-output stream computed note by note from the ROM contents.
module tb_tone_sequencer;

   localparam int ADDR_W  = 4;
   localparam int DELAY_W = 8;
   localparam int NOTES   = 3;
   localparam int BEATS   = 16;
   localparam int BEAT_W  = 5;
   localparam int SAMP_W  = 16;
   localparam int AMP     = 100;
   localparam int ROM_LAT = 1;
   localparam int MARKER  = 255;

   typedef struct packed {
      logic signed [SAMP_W-1:0] s;
      logic                     p;
      logic                     d;
      logic [ADDR_W-1:0]        a;
   } obs_t;

   logic                     CLOCK_50 = 1'b0;
   logic                     resetn;
   logic                     start;
   logic                     stop;
   logic                     loop_en;
   logic [ADDR_W-1:0]        rom_addr;
   logic [DELAY_W-1:0]       rom_q = '0;
   logic signed [SAMP_W-1:0] sample;
   logic                     playing;
   logic                     done;

   logic [DELAY_W-1:0] rom_mem [0:15];
   obs_t               exp_q [$];
   int                 n_tests = 0;
   int                 n_fail  = 0;

   tone_sequencer #(
      .ADDR_W(ADDR_W), .DELAY_W(DELAY_W), .NOTE_COUNT(NOTES),
      .BEAT_CYCLES(BEATS), .BEAT_W(BEAT_W), .SAMPLE_W(SAMP_W),
      .AMPLITUDE(AMP), .ROM_LAT(ROM_LAT)
   ) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .stop(stop),
      .loop_en(loop_en), .rom_addr(rom_addr), .rom_q(rom_q),
      .sample(sample), .playing(playing), .done(done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Single-cycle-latency note ROM.
   always @(posedge CLOCK_50) rom_q <= rom_mem[rom_addr];

   function automatic obs_t mk(input int s, input bit p, input bit d, input int a);
      obs_t o;
      o.s = SAMP_W'(s);
      o.p = p;
      o.d = d;
      o.a = ADDR_W'(a);
      return o;
   endfunction

   function automatic obs_t get_obs();
      obs_t o;
      o.s = sample;
      o.p = playing;
      o.d = done;
      o.a = rom_addr;
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("sample=%0d playing=%0b done=%0b rom_addr=%0d", o.s, o.p, o.d, o.a);
   endfunction

   // Reference: each note is ROM_LAT+1 silent fetch cycles followed by BEATS
   // cycles of a square wave that starts low and flips every hp cycles.
   task automatic build_expected(input int iters, input bit loop_mode);
      int hp;
      int s;
      exp_q.delete();
      for (int it = 0; it < iters; it++) begin
         for (int k = 0; k < NOTES; k++) begin
            for (int f = 0; f <= ROM_LAT; f++) exp_q.push_back(mk(0, 1'b1, 1'b0, 0 + k));
            hp = int'(rom_mem[k]);
            if (hp == MARKER) break;
            for (int i = 0; i < BEATS; i++) begin
               if (hp == 0) s = 0;
               else s = (((i / hp) % 2) == 0) ? -AMP : AMP;
               exp_q.push_back(mk(s, 1'b1, 1'b0, k));
            end
         end
      end
      if (!loop_mode) begin
         exp_q.push_back(mk(0, 1'b0, 1'b1, 0));
         exp_q.push_back(mk(0, 1'b0, 1'b0, 0));
      end
   endtask

   task automatic go_idle();
      @(negedge CLOCK_50);
      start = 1'b0;
      stop  = 1'b1;
      @(negedge CLOCK_50);
      stop  = 1'b0;
   endtask

   // Raise start; returns at the negedge showing the first FETCH cycle.
   task automatic begin_play(input bit hold);
      start = 1'b1;
      @(negedge CLOCK_50);
      start = hold;
   endtask

   task automatic test_reset();
      obs_t o;
      resetn = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      for (int i = 0; i < 16; i++) rom_mem[i] = '0;
      #1;
      o = get_obs();
      n_tests++;
      if (o !== mk(0, 1'b0, 1'b0, 0)) begin
         n_fail++;
         $display("FAIL reset_async: got %s, want all zero", fmt(o));
      end
      @(negedge CLOCK_50);
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLOCK_50);
         o = get_obs();
         n_tests++;
         if (o !== mk(0, 1'b0, 1'b0, 0)) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: got %s, want all zero", i, fmt(o));
         end
      end
   endtask

   task automatic test_stream(input string name, input int iters, input bit loop_mode);
      obs_t o;
      loop_en = loop_mode;
      build_expected(iters, loop_mode);
      begin_play(1'b0);
      foreach (exp_q[i]) begin
         if (i > 0) @(negedge CLOCK_50);
         o = get_obs();
         n_tests++;
         if (o !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %s, want %s", name, i, fmt(o), fmt(exp_q[i]));
         end
      end
      go_idle();
      loop_en = 1'b0;
   endtask

   task automatic test_oneshot();
      rom_mem[0] = 8'd4; rom_mem[1] = 8'd0; rom_mem[2] = 8'd2;
      test_stream("oneshot", 1, 1'b0);
   endtask

   task automatic test_loop();
      rom_mem[0] = 8'd4; rom_mem[1] = 8'd0; rom_mem[2] = 8'd2;
      test_stream("loop", 3, 1'b1);
   endtask

   task automatic test_marker();
      rom_mem[0] = 8'd4; rom_mem[1] = 8'hFF; rom_mem[2] = 8'd2;
      test_stream("marker", 1, 1'b0);
   endtask

   task automatic test_random();
      bit lm;
      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < NOTES; k++) begin
            if ($urandom_range(0, 7) == 0) rom_mem[k] = 8'hFF;
            else if ($urandom_range(0, 4) == 0) rom_mem[k] = 8'd0;
            else rom_mem[k] = DELAY_W'($urandom_range(1, 20));
         end
         lm = 1'($urandom_range(0, 1));
         test_stream($sformatf("random%0d", t), lm ? 2 : 1, lm);
      end
   endtask

   task automatic test_stop();
      obs_t o;
      rom_mem[0] = 8'd4; rom_mem[1] = 8'd0; rom_mem[2] = 8'd2;
      build_expected(1, 1'b0);
      begin_play(1'b0);
      for (int i = 0; i < ROM_LAT + 1 + 7; i++) begin
         if (i > 0) @(negedge CLOCK_50);
         o = get_obs();
         n_tests++;
         if (o !== exp_q[i]) begin
            n_fail++;
            $display("FAIL stop_pre[%0d]: got %s, want %s", i, fmt(o), fmt(exp_q[i]));
         end
      end
      stop = 1'b1;
      @(negedge CLOCK_50);
      stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge CLOCK_50);
         o = get_obs();
         n_tests++;
         if (o !== mk(0, 1'b0, 1'b0, 0)) begin
            n_fail++;
            $display("FAIL stop_idle[%0d]: got %s, want all zero", i, fmt(o));
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t o;
      rom_mem[0] = 8'd3; rom_mem[1] = 8'd1; rom_mem[2] = 8'd0;
      build_expected(1, 1'b0);
      // With start held, the cycle after done is already the next FETCH.
      void'(exp_q.pop_back());
      exp_q.push_back(mk(0, 1'b1, 1'b0, 0));
      exp_q.push_back(mk(0, 1'b1, 1'b0, 0));
      begin_play(1'b1);
      foreach (exp_q[i]) begin
         if (i > 0) @(negedge CLOCK_50);
         o = get_obs();
         n_tests++;
         if (o !== exp_q[i]) begin
            n_fail++;
            $display("FAIL start_held[%0d]: got %s, want %s", i, fmt(o), fmt(exp_q[i]));
         end
      end
      go_idle();
      start = 1'b1;
      stop  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLOCK_50);
         o = get_obs();
         n_tests++;
         if (o !== mk(0, 1'b0, 1'b0, 0)) begin
            n_fail++;
            $display("FAIL start_stop_idle[%0d]: got %s, want all zero", i, fmt(o));
         end
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic test_async_reset();
      obs_t o;
      rom_mem[0] = 8'd4; rom_mem[1] = 8'd0; rom_mem[2] = 8'd2;
      begin_play(1'b0);
      repeat (ROM_LAT + 1 + 5) @(negedge CLOCK_50);
      #2 resetn = 1'b0;
      #1;
      o = get_obs();
      n_tests++;
      if (o !== mk(0, 1'b0, 1'b0, 0)) begin
         n_fail++;
         $display("FAIL async_reset: got %s, want all zero", fmt(o));
      end
      @(negedge CLOCK_50);
      #3 resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLOCK_50);
         o = get_obs();
         n_tests++;
         if (o !== mk(0, 1'b0, 1'b0, 0)) begin
            n_fail++;
            $display("FAIL post_reset_idle[%0d]: got %s, want all zero", i, fmt(o));
         end
      end
      begin_play(1'b0);
      o = get_obs();
      n_tests++;
      if (o !== mk(0, 1'b1, 1'b0, 0)) begin
         n_fail++;
         $display("FAIL post_reset_start: got %s, want %s", fmt(o), fmt(mk(0, 1'b1, 1'b0, 0)));
      end
      go_idle();
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_loop();
      test_marker();
      test_stop();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
